// File: rtl/pea_slot_arbiter.sv
// pea_slot_arbiter: round-robin hand-out of pea slots to plants, per-frame motion.
// Optional per-requester cooldown enabled by defining PEA_COOLDOWN_EN.
module pea_slot_arbiter #(
   parameter int         NUM_REQ   = 8,
   parameter int         NUM_SLOTS = 4,
   parameter int         SPEED     = 4,
   parameter logic [9:0] X_LIMIT   = 10'd783,
   parameter int         COOLDOWN  = 30
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   frame_tick,
   input  logic [NUM_REQ-1:0]     fire_req,
   input  logic [NUM_REQ*10-1:0]  req_x,
   input  logic [NUM_REQ*3-1:0]   req_lane,
   input  logic [NUM_SLOTS-1:0]   hit_clear,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_SLOTS-1:0]   slot_active,
   output logic [NUM_SLOTS*10-1:0] slot_x,
   output logic [NUM_SLOTS*3-1:0] slot_lane,
   output logic                   full,
   output logic [15:0]            fired_count
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic [PW-1:0]        rr_ptr;
   logic [NUM_REQ-1:0]   cooldown_mask;
   logic [NUM_REQ-1:0]   eligible;
   logic                 win_vld;
   logic [PW-1:0]        win_idx;
   logic                 free_vld;
   logic [SW-1:0]        free_idx;
   logic                 take;
   logic [9:0]           spawn_x;
   logic [2:0]           spawn_lane;
   logic [NUM_SLOTS-1:0] act_nxt;
   logic [NUM_SLOTS-1:0] clr;
   logic [NUM_SLOTS-1:0] alloc;
   logic [NUM_SLOTS-1:0] adv;
   logic [NUM_SLOTS-1:0] retire;
   logic [10:0]          sum [NUM_SLOTS];

   assign eligible = fire_req & ~cooldown_mask;

   always_comb begin
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!win_vld && eligible[j]) begin
            win_vld = 1'b1;
            win_idx = PW'(j);
         end
      end
   end

   // Free slot is taken from pre-hit_clear state; cleared slots wait a cycle.
   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (!free_vld && !slot_active[s]) begin
            free_vld = 1'b1;
            free_idx = SW'(s);
         end
      end
   end

   assign take = win_vld && !full && free_vld;

   always_comb begin
      spawn_x    = '0;
      spawn_lane = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PW'(i)) begin
            spawn_x    = req_x[i*10 +: 10];
            spawn_lane = req_lane[i*3 +: 3];
         end
      end
   end

   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         sum[s]     = {1'b0, slot_x[s*10 +: 10]} + 11'(SPEED);
         clr[s]     = hit_clear[s] && slot_active[s];
         alloc[s]   = take && (free_idx == SW'(s));
         adv[s]     = frame_tick && slot_active[s] && !clr[s] && !alloc[s];
         retire[s]  = adv[s] && (sum[s] >= {1'b0, X_LIMIT});
         act_nxt[s] = (slot_active[s] && !clr[s] && !retire[s]) || alloc[s];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant       <= '0;
         slot_active <= '0;
         slot_x      <= '0;
         slot_lane   <= '0;
         full        <= 1'b0;
         fired_count <= '0;
         rr_ptr      <= '0;
      end else begin
         grant       <= '0;
         slot_active <= act_nxt;
         full        <= &act_nxt;
         if (take) begin
            grant[win_idx] <= 1'b1;
            rr_ptr <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
            if (fired_count != 16'hFFFF)
               fired_count <= fired_count + 16'd1;
         end
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (alloc[s]) begin
               slot_x[s*10 +: 10]  <= spawn_x;
               slot_lane[s*3 +: 3] <= spawn_lane;
            end else if (adv[s] && !retire[s]) begin
               slot_x[s*10 +: 10] <= sum[s][9:0];
            end
         end
      end
   end

`ifdef PEA_COOLDOWN_EN
   logic [5:0] cd_cnt [NUM_REQ];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++)
            cd_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (take && win_idx == PW'(i))
               cd_cnt[i] <= 6'(COOLDOWN);
            else if (frame_tick && cd_cnt[i] != '0)
               cd_cnt[i] <= cd_cnt[i] - 6'd1;
         end
      end
   end

   always_comb begin
      cooldown_mask = '0;
      for (int i = 0; i < NUM_REQ; i++)
         cooldown_mask[i] = (cd_cnt[i] != '0);
   end
`else
   assign cooldown_mask = '0;
`endif

endmodule

// File: tb/tb_pea_slot_arbiter.sv
// tb_pea_slot_arbiter: vector table plus directed sequences with an
// expected-result queue checked one cycle after each drive.
module tb_pea_slot_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [7:0]  fire_req = '0;
   logic [79:0] req_x = '0;
   logic [23:0] req_lane = '0;
   logic [3:0]  hit_clear = '0;
   logic [7:0]  grant;
   logic [3:0]  slot_active;
   logic [39:0] slot_x;
   logic [11:0] slot_lane;
   logic        full;
   logic [15:0] fired_count;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0]  fire;
      logic [3:0]  hit;
      logic        tick;
      logic [7:0]  g;
      logic [3:0]  act;
      logic        f;
      logic [15:0] cnt;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[12];

   pea_slot_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_tick  (frame_tick),
      .fire_req    (fire_req),
      .req_x       (req_x),
      .req_lane    (req_lane),
      .hit_clear   (hit_clear),
      .grant       (grant),
      .slot_active (slot_active),
      .slot_x      (slot_x),
      .slot_lane   (slot_lane),
      .full        (full),
      .fired_count (fired_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [7:0] fire, logic [3:0] hit, logic tick,
                               logic [7:0] g, logic [3:0] act, logic f,
                               logic [15:0] cnt);
      vec_t v;
      v.fire = fire; v.hit = hit; v.tick = tick;
      v.g = g; v.act = act; v.f = f; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [9:0] sx(int s);
      return slot_x[s*10 +: 10];
   endfunction

   function automatic logic [2:0] sl(int s);
      return slot_lane[s*3 +: 3];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(int i, int x, int lane);
      req_x[i*10 +: 10]  = 10'(x);
      req_lane[i*3 +: 3] = 3'(lane);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(string name, vec_t v);
      vec_t e;
      fire_req   = v.fire;
      hit_clear  = v.hit;
      frame_tick = v.tick;
      sb.push_back(v);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk({name, ".grant"}, grant, e.g);
      chk({name, ".active"}, slot_active, e.act);
      chk({name, ".full"}, full, e.f);
      chk({name, ".count"}, fired_count, e.cnt);
   endtask

   task automatic do_reset();
      fire_req = '0; hit_clear = '0; frame_tick = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = mk(8'hFF, 4'h0, 0, 8'h01, 4'b0001, 0, 1);
      tbl[1]  = mk(8'hFF, 4'h0, 0, 8'h02, 4'b0011, 0, 2);
      tbl[2]  = mk(8'hFF, 4'h0, 0, 8'h04, 4'b0111, 0, 3);
      tbl[3]  = mk(8'hFF, 4'h0, 0, 8'h08, 4'b1111, 1, 4);
      tbl[4]  = mk(8'hFF, 4'h0, 0, 8'h00, 4'b1111, 1, 4);
      tbl[5]  = mk(8'hFF, 4'h2, 0, 8'h00, 4'b1101, 0, 4);
      tbl[6]  = mk(8'hFF, 4'h0, 0, 8'h10, 4'b1111, 1, 5);
      tbl[7]  = mk(8'h00, 4'h0, 0, 8'h00, 4'b1111, 1, 5);
      tbl[8]  = mk(8'h00, 4'h0, 1, 8'h00, 4'b1111, 1, 5);
      tbl[9]  = mk(8'h80, 4'h1, 1, 8'h00, 4'b1110, 0, 5);
      tbl[10] = mk(8'h80, 4'h0, 0, 8'h80, 4'b1111, 1, 6);
      tbl[11] = mk(8'h00, 4'h0, 0, 8'h00, 4'b1111, 1, 6);

      @(negedge clk);
      @(negedge clk);
      chk("rst.grant", grant, 0);
      chk("rst.active", slot_active, 0);
      chk("rst.x", slot_x, 0);
      chk("rst.full", full, 0);
      chk("rst.count", fired_count, 0);
      reset_n = 1'b1;

      // single request from plant 2
      set_req(2, 100, 3);
      step("single", mk(8'h04, 0, 0, 8'h04, 4'b0001, 0, 1));
      chk("single.x", sx(0), 100);
      chk("single.lane", sl(0), 3);
      step("single_drop", mk(8'h00, 0, 0, 8'h00, 4'b0001, 0, 1));

      // round robin fill, hit_clear refill, clear+tick collision
      do_reset();
      for (int i = 0; i < 8; i++) set_req(i, 100 + 20 * i, i % 5);
      for (int i = 0; i < 12; i++) step($sformatf("tbl%0d", i), tbl[i]);
      chk("tbl.x0", sx(0), 240);
      chk("tbl.lane0", sl(0), 2);
      chk("tbl.x1", sx(1), 188);
      chk("tbl.lane1", sl(1), 4);
      chk("tbl.x2", sx(2), 148);
      chk("tbl.x3", sx(3), 168);

      // right edge retire
      do_reset();
      set_req(0, 776, 1);
      step("edge_spawn", mk(8'h01, 0, 0, 8'h01, 4'b0001, 0, 1));
      step("edge_t1", mk(8'h00, 0, 1, 8'h00, 4'b0001, 0, 1));
      chk("edge_t1.x", sx(0), 780);
      step("edge_t2", mk(8'h00, 0, 1, 8'h00, 4'b0000, 0, 1));
      chk("edge_t2.x", sx(0), 780);
      set_req(1, 779, 0);
      step("b779", mk(8'h02, 0, 0, 8'h02, 4'b0001, 0, 2));
      step("b779_t", mk(8'h00, 0, 1, 8'h00, 4'b0000, 0, 2));
      set_req(2, 778, 0);
      step("b778", mk(8'h04, 0, 0, 8'h04, 4'b0001, 0, 3));
      step("b778_t", mk(8'h00, 0, 1, 8'h00, 4'b0001, 0, 3));
      chk("b778_t.x", sx(0), 782);

      // re-grant behaviour of a requester that keeps asking
      do_reset();
      set_req(5, 10, 0);
      set_req(6, 20, 1);
`ifdef PEA_COOLDOWN_EN
      step("cd_g5", mk(8'h20, 0, 0, 8'h20, 4'b0001, 0, 1));
      step("cd_g6", mk(8'h60, 0, 0, 8'h40, 4'b0011, 0, 2));
      for (int k = 1; k <= 30; k++)
         step($sformatf("cd_tick%0d", k), mk(8'h20, 0, 1, 8'h00, 4'b0011, 0, 2));
      step("cd_regrant", mk(8'h20, 0, 0, 8'h20, 4'b0111, 0, 3));
`else
      step("nocd_g5", mk(8'h20, 0, 0, 8'h20, 4'b0001, 0, 1));
      step("nocd_g5b", mk(8'h20, 0, 0, 8'h20, 4'b0011, 0, 2));
      step("nocd_drop", mk(8'h00, 0, 0, 8'h00, 4'b0011, 0, 2));
`endif

      // asynchronous reset mid-cycle, pointer restarts at requester 0
      do_reset();
      step("mr_g4", mk(8'h70, 0, 0, 8'h10, 4'b0001, 0, 1));
      step("mr_g5", mk(8'h70, 0, 0, 8'h20, 4'b0011, 0, 2));
      step("mr_g6", mk(8'h70, 0, 0, 8'h40, 4'b0111, 0, 3));
      fire_req = 8'h81;
      #2 reset_n = 1'b0;
      #1;
      chk("mr.grant", grant, 0);
      chk("mr.active", slot_active, 0);
      chk("mr.x", slot_x, 0);
      chk("mr.lane", slot_lane, 0);
      chk("mr.full", full, 0);
      chk("mr.count", fired_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step("mr_after", mk(8'h81, 0, 0, 8'h01, 4'b0001, 0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
